// File: rtl/popcount_pkg.sv
// Shared types and helpers for the pipelined popcount / frame accumulator.
package popcount_pkg;

    typedef struct packed {
        logic valid;
        logic mode;
        logic last;
    } beat_sb_t;

    function automatic int num_levels(input int vector_size);
        return $clog2(vector_size);
    endfunction

    // Saturating add at w bits. Bit w of the result flags saturation and
    // bits [w-1:0] carry the clamped sum; callers keep the low w+1 bits.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        if (sum > max_val) return max_val | (33'd1 << w);
        return sum;
    endfunction

endpackage

// File: rtl/popcount_tree_stage.sv
// One registered adder-tree level: sums adjacent pairs and carries the beat sideband.
module popcount_tree_stage
    import popcount_pkg::*;
#(
    parameter int IN_COUNT = 2,
    parameter int IN_WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [IN_COUNT*IN_WIDTH-1:0]         in_sums,
    input  beat_sb_t                             in_sb,
    output logic [(IN_COUNT/2)*(IN_WIDTH+1)-1:0] out_sums,
    output beat_sb_t                             out_sb
);

    localparam int OUT_COUNT = IN_COUNT / 2;
    localparam int OUT_WIDTH = IN_WIDTH + 1;

    logic [OUT_COUNT*OUT_WIDTH-1:0] sums_d;

    always_comb begin
        sums_d = '0;
        for (int i = 0; i < OUT_COUNT; i++) begin
            sums_d[i*OUT_WIDTH +: OUT_WIDTH] =
                OUT_WIDTH'(in_sums[(2*i)*IN_WIDTH +: IN_WIDTH]) +
                OUT_WIDTH'(in_sums[(2*i+1)*IN_WIDTH +: IN_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sums <= '0;
            out_sb   <= '0;
        end else if (en) begin
            out_sums <= sums_d;
            out_sb   <= in_sb;
        end
    end

endmodule

// File: rtl/popcount_pipe_accumulator.sv
// Pipelined popcount with valid/ready stream and optional saturating per-frame accumulation.
module popcount_pipe_accumulator
    import popcount_pkg::*;
#(
    parameter int VECTOR_SIZE = 16,
    parameter int ACC_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VECTOR_SIZE-1:0] in_vector,
    input  logic                   in_mode,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_count,
    output logic                   out_sat
);

    localparam int NUM_LEVELS = num_levels(VECTOR_SIZE);
    localparam int TREE_W     = NUM_LEVELS + 1;

    if (VECTOR_SIZE < 2 || (VECTOR_SIZE & (VECTOR_SIZE - 1)) != 0) begin : g_bad_size
        $error("VECTOR_SIZE must be a power of two >= 2");
    end
    if (ACC_WIDTH < TREE_W || ACC_WIDTH > 31) begin : g_bad_acc
        $error("ACC_WIDTH must be in [clog2(VECTOR_SIZE)+1, 31]");
    end

    logic     advance;
    beat_sb_t in_sb;

    // Single global enable: the whole pipe stalls only when the output is occupied and blocked.
    assign advance      = !out_valid || out_ready;
    assign in_ready     = advance && !rst;
    assign in_sb.valid  = in_valid && in_ready;
    assign in_sb.mode   = in_mode;
    assign in_sb.last   = in_last;

    for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
        localparam int IC = VECTOR_SIZE >> l;
        localparam int IW = l + 1;

        logic [IC*IW-1:0]          stage_in;
        beat_sb_t                  sb_in;
        logic [(IC/2)*(IW+1)-1:0]  sums;
        beat_sb_t                  sb;

        if (l == 0) begin : g_src
            assign stage_in = in_vector;
            assign sb_in    = in_sb;
        end else begin : g_src
            assign stage_in = g_lvl[l-1].sums;
            assign sb_in    = g_lvl[l-1].sb;
        end

        popcount_tree_stage #(
            .IN_COUNT (IC),
            .IN_WIDTH (IW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (advance),
            .in_sums  (stage_in),
            .in_sb    (sb_in),
            .out_sums (sums),
            .out_sb   (sb)
        );
    end

    logic [TREE_W-1:0]    tree_sum;
    beat_sb_t             tree_sb;
    logic [ACC_WIDTH-1:0] tree_ext;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sat_flag;
    logic [ACC_WIDTH:0]   add_res;
    logic                 add_sat;
    logic [ACC_WIDTH-1:0] add_val;

    assign tree_sum = g_lvl[NUM_LEVELS-1].sums;
    assign tree_sb  = g_lvl[NUM_LEVELS-1].sb;
    assign tree_ext = ACC_WIDTH'(tree_sum);
    assign add_res  = (ACC_WIDTH+1)'(sat_add(32'(acc), 32'(tree_ext), ACC_WIDTH));
    assign add_sat  = add_res[ACC_WIDTH];
    assign add_val  = add_res[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
            acc       <= '0;
            sat_flag  <= 1'b0;
        end else if (advance) begin
            if (!tree_sb.valid) begin
                out_valid <= 1'b0;
            end else if (!tree_sb.mode) begin
                // Per-word beats bypass the accumulator, so they may sit inside an open frame.
                out_valid <= 1'b1;
                out_count <= tree_ext;
                out_sat   <= 1'b0;
            end else if (!tree_sb.last) begin
                out_valid <= 1'b0;
                acc       <= add_val;
                sat_flag  <= sat_flag | add_sat;
            end else begin
                out_valid <= 1'b1;
                out_count <= add_val;
                out_sat   <= sat_flag | add_sat;
                acc       <= '0;
                sat_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/popcount_pipe_accumulator.md
Name: popcount_pipe_accumulator

Overview:
- Pipelined, parametrised population counter with a valid/ready stream interface.
- Registered binary adder tree, one register per level; optional per-frame accumulation mode with saturation.
- Successor to the combinational bit-vector adders. Sits in datapath blocks that need a set-bit count per word or per multi-word frame under backpressure.

Parameters:
VECTOR_SIZE, 16, input word width; power of two, >= 2 (elaboration error otherwise)
ACC_WIDTH, 8, output/accumulator width; must be >= $clog2(VECTOR_SIZE)+1 (elaboration error otherwise)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts beat this cycle
in_vector  input  VECTOR_SIZE  word to count
in_mode  input  1  0 = per-word count, 1 = accumulate into frame
in_last  input  1  last beat of frame (ignored when in_mode=0)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_count  output  ACC_WIDTH  word count or frame total
out_sat  output  1  frame total saturated (always 0 for per-word results)

Behaviour:
- Reset: every stage valid = 0, accumulator = 0, sticky sat flag = 0.
- Reset outputs: out_valid = 0, out_count = 0, out_sat = 0. in_ready = 0 while rst is high.
- Reset mid-operation discards all in-flight beats and any partial frame.
- Pipeline:
  - NUM_LEVELS = $clog2(VECTOR_SIZE) tree stages.
  - Stage L holds VECTOR_SIZE>>L partial sums, each L+1 bits wide, plus the beat's valid, mode and last.
  - One output stage follows the tree. Latency from accepted beat to out_valid is NUM_LEVELS+1 cycles (5 for VECTOR_SIZE=16).
- Handshake:
  - Global enable: advance = !out_valid || out_ready; in_ready = advance (when not in reset).
  - Beat is accepted when in_valid && in_ready.
  - When advance = 0, every stage and the accumulator hold.
  - Bubbles are not collapsed.
  - out_count/out_sat are stable while out_valid && !out_ready.
- Output stage, on advance with a valid tree result T, split by the beat's mode and last:
  - mode=0: out_count = T zero-extended, out_sat = 0, out_valid = 1. Accumulator and sat flag untouched, so a per-word beat may sit inside an open frame.
  - mode=1, last=0: acc <= sat_add(acc, T); out_valid <= 0; sat flag sets if the add saturated.
  - mode=1, last=1: out_count = sat_add(acc, T); out_sat = sat flag OR this add saturated; out_valid = 1. Then acc <= 0 and sat flag <= 0 in the same cycle.
- No valid tree result on advance: out_valid <= 0.
- sat_add(a, b) = min(a + b, 2^ACC_WIDTH - 1), computed at ACC_WIDTH+1 bits.
- Single-beat frame (mode=1, last=1 on first beat): out_count = T.
- Frame total exactly 2^ACC_WIDTH - 1: out_sat = 0.
- Simultaneous out_ready and new result: the old result leaves and the new one loads in the same cycle (full throughput, 1 beat/cycle).

Decomposition:
- Shared package popcount_pkg: sat_add function; NUM_LEVELS computation; a beat sideband struct (valid, mode, last).
- Sub-module popcount_tree_stage:
  - Parameters IN_COUNT and IN_WIDTH.
  - Registers pairwise sums (IN_COUNT/2 outputs, IN_WIDTH+1 bits) plus sideband when enable is high.
- Top instantiates NUM_LEVELS stages via a generate loop; level 0 inputs are the raw bits.

Test Plan:
- VECTOR_SIZE=16, out_ready=1. Beats 0x0000, 0xFFFF, 0xA5A5 in mode=0 on consecutive cycles -> out_count 0, 16, 8 on cycles 5, 6, 7 after the first accept; out_sat = 0.
- Frame 0x000F, 0x00FF, 0x0001 (mode=1, last on third) -> single result out_count = 13, out_sat = 0. No out_valid for the first two beats.
- ACC_WIDTH=8: 17 beats of 0xFFFF in mode=1, last on 17th (raw total 272) -> out_count = 255, out_sat = 1. Next frame of one 0x0003 last beat -> out_count = 2, out_sat = 0.
- Backpressure: out_ready=0 for 10 cycles while streaming mode=0 beats -> in_ready drops once out_valid is set; held result stable; no beat lost or duplicated; results in order once out_ready returns to 1.
- Interleave: frame beat 0x0007 (mode=1), then per-word 0x0003 (mode=0), then 0x0001 (mode=1, last) -> outputs 2 then 4.
- rst pulsed mid-frame after two mode=1 beats -> out_valid = 0 next cycle. A following single last beat 0x0001 -> out_count = 1.
